// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter: iterative AES MixColumns / InvMixColumns on a 128-bit state.
// Transforms COLS_PER_CYCLE columns per clock, so NSTEP = 4/COLS_PER_CYCLE busy
// cycles are needed per state. Valid/ready handshakes are used on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input state offered
//   in_ready   block can accept an input this cycle
//   in_data    input state (column c at [127-32c -: 32], row r at [127-32c-8r -: 8])
//   in_inv     0 = MixColumns, 1 = InvMixColumns (sampled with in_data)
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_data   transformed state, same byte layout as in_data
//   busy       high while a state is being transformed or waiting to be taken
module mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NSTEP = 4 / COLS_PER_CYCLE;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Multiply by 02 in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward column mix: rows 02 03 01 01 rotated.
    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Returns {x*0e, x*0b, x*0d, x*09} built from one shared xtime chain.
    function automatic logic [31:0] inv_mults(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
    endfunction

    // Inverse column mix: rows 0e 0b 0d 09 rotated.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] e0, b0, d0, n0, e1, b1, d1, n1, e2, b2, d2, n2, e3, b3, d3, n3;
        {e0, b0, d0, n0} = inv_mults(c[31:24]);
        {e1, b1, d1, n1} = inv_mults(c[23:16]);
        {e2, b2, d2, n2} = inv_mults(c[15:8]);
        {e3, b3, d3, n3} = inv_mults(c[7:0]);
        return {e0 ^ b1 ^ d2 ^ n3,
                n0 ^ e1 ^ b2 ^ d3,
                d0 ^ n1 ^ e2 ^ b3,
                b0 ^ d1 ^ n2 ^ e3};
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_step;
    logic [127:0]    r_in;
    logic            r_inv;
    logic [127:0]    r_result;
    logic            w_accept;
    logic            w_last;
    logic [6:0]      w_base    [COLS_PER_CYCLE];
    logic [31:0]     w_col_out [COLS_PER_CYCLE];

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_step == SW'(NSTEP - 1));
    assign out_data = r_result;

    // Column lanes: lane j handles column step*C + j of the latched state.
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
        logic [1:0]  w_col_idx;
        logic [31:0] w_col_in;
        assign w_col_idx = 2'(int'(r_step) * COLS_PER_CYCLE + j);
        assign w_base[j] = 7'd127 - {w_col_idx, 5'd0};
        assign w_col_in  = r_in[w_base[j] -: 32];
        if (INV_EN) begin : g_inv
            assign w_col_out[j] = r_inv ? mix_inv(w_col_in) : mix_fwd(w_col_in);
        end else begin : g_fwd
            assign w_col_out[j] = mix_fwd(w_col_in);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and handshake outputs; DONE can hand off and accept on the same edge.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_BUSY;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_BUSY;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    w_next = in_valid ? S_BUSY : S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture input on accept, write C result columns per busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in     <= 128'h0;
            r_inv    <= 1'b0;
            r_step   <= '0;
            r_result <= 128'h0;
        end else if (w_accept) begin
            r_in   <= in_data;
            r_inv  <= INV_EN ? in_inv : 1'b0;
            r_step <= '0;
        end else if (r_state == S_BUSY) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                r_result[w_base[j] -: 32] <= w_col_out[j];
            end
            r_step <= w_last ? '0 : r_step + 1'b1;
        end else begin
            r_step <= r_step;
        end
    end

endmodule

// File: tb/tb_mixcolumns_iter.sv
module tb_mixcolumns_iter;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] in_data   [4];
    logic         in_inv    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] out_data  [4];
    logic         busy      [4];

    logic [127:0] exp_q [4][$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0: C=1, u1: C=2, u2: C=4, u3: C=2 forward-only
    mixcolumns_iter #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
    mixcolumns_iter #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
    mixcolumns_iter #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));
    mixcolumns_iter #(.COLS_PER_CYCLE(2), .INV_EN(1'b0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_data(out_data[3]), .busy(busy[3]));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake pops and compares one expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (out_valid[u] === 1'b1 && out_ready[u] === 1'b1) begin
                if (exp_q[u].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output_u%0d actual=%h required=none", u, out_data[u]);
                end else begin
                    logic [127:0] e;
                    e = exp_q[u].pop_front();
                    check($sformatf("out_data_u%0d", u), out_data[u], e);
                end
            end
        end
    end

    // Offer one state and hold it until accepted; returns just after the accept edge.
    task automatic send(input int u, input logic [127:0] d, input logic inv, input logic [127:0] e);
        bit ok;
        ok = 1'b0;
        exp_q[u].push_back(e);
        @(posedge clk); #1;
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_inv[u]   = inv;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready[u]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_u%0d actual=not_ready required=ready", u);
        end
    endtask

    // Called just after the accept edge: result must appear exactly nstep edges later.
    task automatic lat(input int u, input int nstep);
        for (int i = 1; i < nstep; i++) begin
            @(posedge clk); #1;
            check($sformatf("early_valid_u%0d_cyc%0d", u, i), 128'(out_valid[u]), 128'd0);
        end
        @(posedge clk); #1;
        check($sformatf("latency_valid_u%0d", u), 128'(out_valid[u]), 128'd1);
        check($sformatf("done_busy_u%0d", u), 128'(busy[u]), 128'd1);
        if (out_ready[u]) begin
            @(posedge clk); #1;
            check($sformatf("single_cycle_valid_u%0d", u), 128'(out_valid[u]), 128'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 4; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = 128'h0;
            in_inv[u]    = 1'b0;
            out_ready[u] = 1'b1;
        end
        #1;
        for (int u = 0; u < 4; u++) begin
            check($sformatf("reset_out_valid_u%0d", u), 128'(out_valid[u]), 128'd0);
            check($sformatf("reset_busy_u%0d", u), 128'(busy[u]), 128'd0);
            check($sformatf("reset_out_data_u%0d", u), out_data[u], 128'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int u = 0; u < 4; u++) begin
            check($sformatf("post_reset_in_ready_u%0d", u), 128'(in_ready[u]), 128'd1);
        end

        // Forward FIPS-197 state, one column per cycle.
        send(0, FIPS_IN, 1'b0, FIPS_OUT);
        lat(0, 4);

        // Two columns per cycle, inverse then forward.
        send(1, FIPS_OUT, 1'b1, FIPS_IN);
        lat(1, 2);
        send(1, FIPS_IN, 1'b0, FIPS_OUT);
        lat(1, 2);

        // Whole state per cycle: column vectors forward, inverse round trip, FIPS state.
        send(2, COL_IN, 1'b0, COL_OUT);
        lat(2, 1);
        send(2, COL_OUT, 1'b1, COL_IN);
        lat(2, 1);
        send(2, FIPS_IN, 1'b0, FIPS_OUT);
        lat(2, 1);

        // Backpressure: hold in DONE, then hand off and accept on the same edge.
        out_ready[0] = 1'b0;
        send(0, FIPS_IN, 1'b0, FIPS_OUT);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid[0]) break;
        end
        check("bp_valid_seen", 128'(out_valid[0]), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_stable", 128'(out_valid[0]), 128'd1);
            check("bp_data_stable", out_data[0], FIPS_OUT);
            check("bp_in_ready_low", 128'(in_ready[0]), 128'd0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = COL_IN;
        in_inv[0]    = 1'b0;
        exp_q[0].push_back(COL_OUT);
        @(negedge clk);
        check("bp_in_ready_on_release", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("bp_back_to_back_busy", 128'(busy[0]), 128'd1);
        check("bp_back_to_back_valid", 128'(out_valid[0]), 128'd0);
        lat(0, 4);

        // Asynchronous reset while unit 0 is at step 2.
        send(0, FIPS_IN, 1'b0, FIPS_OUT);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", 128'(busy[0]), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_out_valid", 128'(out_valid[0]), 128'd0);
        check("async_reset_out_data", out_data[0], 128'h0);
        check("async_reset_busy", 128'(busy[0]), 128'd0);
        for (int u = 0; u < 4; u++) exp_q[u].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, COL_IN, 1'b0, COL_OUT);
        lat(0, 4);

        // Forward-only build ignores in_inv.
        send(3, COL_IN, 1'b1, COL_OUT);
        lat(3, 2);

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++) begin
            check($sformatf("scoreboard_drained_u%0d", u), 128'(exp_q[u].size()), 128'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
